cb_filter_seq: RTL and testbench

Sequential counting Bloom filter. Accepts one lookup, insert or remove request at a time and evaluates its `NoHashes` seeded hashes one per cycle against a register-based counter array. It returns hit and error status over a valid/ready response channel. It consumes the `cb_seed_t` seed vectors from `cb_filter_pkg` and is the runtime user of those seeds: the membership tracker in front of caches and ID tables.

---
 rtl/cb_filter_pkg.sv | 39 +++
 rtl/cb_hash_rot.sv | 55 +++++
 rtl/cb_filter_seq.sv | 219 +++++++++++++++++++++
 tb/tb_cb_filter_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_filter_pkg.sv
// -----------------------------------------------------------------------------
// cb_filter_pkg
// Shared types and constants for the counting Bloom filter blocks.
//   cb_seed_t : per-hash seed pair (rotation amount, XOR mask)
//   EgSeeds   : example seed set for a three-hash filter
//   cb_op_e   : request opcode of the sequential filter
//   cb_norm_op: folds the unused opcode encoding onto LOOKUP
// -----------------------------------------------------------------------------
package cb_filter_pkg;

    typedef struct packed {
        logic [31:0] PermuteSeed;
        logic [31:0] XorSeed;
    } cb_seed_t;

    localparam cb_seed_t EgSeed0 = '{PermuteSeed: 32'd0,  XorSeed: 32'h0000_0000};
    localparam cb_seed_t EgSeed1 = '{PermuteSeed: 32'd8,  XorSeed: 32'h0000_0001};
    localparam cb_seed_t EgSeed2 = '{PermuteSeed: 32'd13, XorSeed: 32'h0000_00F0};

    localparam cb_seed_t [2:0] EgSeeds = {EgSeed2, EgSeed1, EgSeed0};

    typedef enum logic [1:0] {
        CB_LOOKUP = 2'd0,
        CB_INSERT = 2'd1,
        CB_REMOVE = 2'd2
    } cb_op_e;

    // Encoding 3 has no operation of its own and behaves as a lookup.
    function automatic cb_op_e cb_norm_op(input logic [1:0] op);
        cb_op_e res;
        case (op)
            2'd1:    res = CB_INSERT;
            2'd2:    res = CB_REMOVE;
            default: res = CB_LOOKUP;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cb_hash_rot.sv
// -----------------------------------------------------------------------------
// cb_hash_rot
// Combinational seeded hash: XOR the key with the (replicated/truncated) seed
// mask, rotate left by PermuteSeed % KeyWidth, then fold all HashWidth-bit
// slices together with XOR (top slice zero-padded).
//   key : input key, KeyWidth bits
//   idx : counter index, HashWidth bits
// -----------------------------------------------------------------------------
module cb_hash_rot
    import cb_filter_pkg::*;
#(
    parameter int unsigned KeyWidth  = 32,
    parameter int unsigned HashWidth = 4,
    parameter cb_seed_t    Seed      = '0
) (
    input  logic [KeyWidth-1:0]  key,
    output logic [HashWidth-1:0] idx
);

    localparam int unsigned NoSlices = (KeyWidth + HashWidth - 1) / HashWidth;
    localparam int unsigned PadWidth = NoSlices * HashWidth;
    localparam int unsigned Rot      = Seed.PermuteSeed % KeyWidth;
    localparam logic [31:0] XorMask  = Seed.XorSeed;

    logic [KeyWidth-1:0] xor_key_s;
    logic [KeyWidth-1:0] rot_key_s;
    logic [PadWidth-1:0] pad_key_s;

    // Seed mask applied bitwise; the 32-bit mask repeats for wider keys.
    always_comb begin
        xor_key_s = '0;
        for (int b = 0; b < int'(KeyWidth); b++) begin
            xor_key_s[b] = key[b] ^ XorMask[b % 32];
        end
    end

    // Constant rotate-left: bit b moves to position (b + Rot) mod KeyWidth.
    always_comb begin
        rot_key_s = '0;
        for (int b = 0; b < int'(KeyWidth); b++) begin
            rot_key_s[(b + int'(Rot)) % int'(KeyWidth)] = xor_key_s[b];
        end
    end

    // Zero-pad to a whole number of slices, then XOR-fold the slices.
    always_comb begin
        pad_key_s                 = '0;
        pad_key_s[KeyWidth-1:0]   = rot_key_s;
        idx                       = '0;
        for (int s = 0; s < int'(NoSlices); s++) begin
            idx = idx ^ pad_key_s[s*HashWidth +: HashWidth];
        end
    end

endmodule

// File: rtl/cb_filter_seq.sv
// -----------------------------------------------------------------------------
// cb_filter_seq
// Sequential counting Bloom filter. One request (lookup/insert/remove) is in
// flight at a time; its NoHashes hashes are checked one per cycle against a
// flip-flop counter array, then (for a performed insert/remove) the counters
// are updated one per cycle, and the result is offered on a valid/ready
// response channel.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : request handshake (ready only in IDLE)
//   req_op_i, req_key_i     : opcode (cb_op_e, 3 = lookup) and key
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_hit_o               : all addressed counters were nonzero
//   rsp_err_o               : insert saturated / remove missed
//   filter_empty_o          : every counter is zero
// -----------------------------------------------------------------------------
module cb_filter_seq
    import cb_filter_pkg::*;
#(
    parameter int unsigned                KeyWidth  = 32,
    parameter int unsigned                HashWidth = 4,
    parameter int unsigned                NoHashes  = 3,
    parameter int unsigned                CntWidth  = 4,
    parameter cb_seed_t [NoHashes-1:0]    Seeds     = EgSeeds
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [KeyWidth-1:0] req_key_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_hit_o,
    output logic                rsp_err_o,
    output logic                filter_empty_o
);

    localparam int unsigned NoCnt   = 2 ** HashWidth;
    localparam int          CntMax  = (2 ** CntWidth) - 1;
    // A counter above this value could overflow if every hash hit it.
    localparam int          OverThr = CntMax - int'(NoHashes);
    localparam int unsigned IdxW    = (NoHashes > 1) ? $clog2(NoHashes) : 1;
    localparam logic [IdxW-1:0] LastHash = IdxW'(NoHashes - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        UPDATE = 2'd2,
        RESP   = 2'd3
    } cb_seq_state_e;

    cb_seq_state_e         state_r,    state_s;
    logic [IdxW-1:0]       hash_cnt_r, hash_cnt_s;
    cb_op_e                op_r,       op_s;
    logic [KeyWidth-1:0]   key_r,      key_s;
    logic                  all_nz_r,   all_nz_s;
    logic                  over_r,     over_s;
    logic                  hit_r,      hit_s;
    logic                  err_r,      err_s;
    logic                  wr_en_s;

    logic [CntWidth-1:0]   cnt_r [NoCnt];
    logic [HashWidth-1:0]  idx_all_s [NoHashes];
    logic [HashWidth-1:0]  idx_sel_s;
    logic [CntWidth-1:0]   cnt_rd_s;
    logic [CntWidth-1:0]   cnt_wr_s;
    logic                  cnt_over_s;
    logic                  empty_s;

    // One hash instance per seed; all hash the registered key.
    for (genvar h = 0; h < int'(NoHashes); h++) begin : g_hash
        cb_hash_rot #(
            .KeyWidth  (KeyWidth),
            .HashWidth (HashWidth),
            .Seed      (Seeds[h])
        ) u_hash (
            .key (key_r),
            .idx (idx_all_s[h])
        );
    end

    // Select the index of the hash being processed this cycle.
    always_comb begin
        idx_sel_s = idx_all_s[0];
        for (int k = 0; k < int'(NoHashes); k++) begin
            idx_sel_s = (hash_cnt_r == IdxW'(k)) ? idx_all_s[k] : idx_sel_s;
        end
    end

    // Single read port, and saturating +/-1 write data for the update phase.
    always_comb begin
        cnt_rd_s   = cnt_r[idx_sel_s];
        cnt_over_s = (int'(cnt_rd_s) > OverThr);
        if (op_r == CB_INSERT) begin
            cnt_wr_s = (cnt_rd_s == {CntWidth{1'b1}}) ? cnt_rd_s : cnt_rd_s + CntWidth'(1);
        end else begin
            cnt_wr_s = (cnt_rd_s == {CntWidth{1'b0}}) ? cnt_rd_s : cnt_rd_s - CntWidth'(1);
        end
    end

    // Empty flag straight off the counter registers.
    always_comb begin
        empty_s = 1'b1;
        for (int k = 0; k < int'(NoCnt); k++) begin
            empty_s = empty_s & (cnt_r[k] == {CntWidth{1'b0}});
        end
    end

    // Next-state, accumulator and response logic.
    always_comb begin
        state_s    = state_r;
        hash_cnt_s = hash_cnt_r;
        op_s       = op_r;
        key_s      = key_r;
        all_nz_s   = all_nz_r;
        over_s     = over_r;
        hit_s      = hit_r;
        err_s      = err_r;
        wr_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid_i) begin
                    op_s       = cb_norm_op(req_op_i);
                    key_s      = req_key_i;
                    hash_cnt_s = '0;
                    all_nz_s   = 1'b1;
                    over_s     = 1'b0;
                    state_s    = CHECK;
                end else begin
                    state_s    = IDLE;
                end
            end
            CHECK: begin
                all_nz_s = all_nz_r & (cnt_rd_s != {CntWidth{1'b0}});
                over_s   = over_r | cnt_over_s;
                if (hash_cnt_r == LastHash) begin
                    hash_cnt_s = '0;
                    // Response is fixed once all hashes are checked; a
                    // performed update cannot change it.
                    hit_s      = all_nz_s;
                    case (op_r)
                        CB_INSERT: err_s = over_s;
                        CB_REMOVE: err_s = ~all_nz_s;
                        default:   err_s = 1'b0;
                    endcase
                    if ((op_r == CB_INSERT) && !over_s) begin
                        state_s = UPDATE;
                    end else if ((op_r == CB_REMOVE) && all_nz_s) begin
                        state_s = UPDATE;
                    end else begin
                        state_s = RESP;
                    end
                end else begin
                    hash_cnt_s = hash_cnt_r + IdxW'(1);
                end
            end
            UPDATE: begin
                wr_en_s = 1'b1;
                if (hash_cnt_r == LastHash) begin
                    hash_cnt_s = '0;
                    state_s    = RESP;
                end else begin
                    hash_cnt_s = hash_cnt_r + IdxW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control and request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            hash_cnt_r <= '0;
            op_r       <= CB_LOOKUP;
            key_r      <= '0;
            all_nz_r   <= 1'b1;
            over_r     <= 1'b0;
            hit_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            hash_cnt_r <= hash_cnt_s;
            op_r       <= op_s;
            key_r      <= key_s;
            all_nz_r   <= all_nz_s;
            over_r     <= over_s;
            hit_r      <= hit_s;
            err_r      <= err_s;
        end
    end

    // Counter array: single write port, one counter per update cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(NoCnt); k++) begin
                cnt_r[k] <= '0;
            end
        end else if (wr_en_s) begin
            cnt_r[idx_sel_s] <= cnt_wr_s;
        end
    end

    assign req_ready_o    = (state_r == IDLE);
    assign rsp_valid_o    = (state_r == RESP);
    assign rsp_hit_o      = hit_r;
    assign rsp_err_o      = err_r;
    assign filter_empty_o = empty_s;

endmodule

// File: tb/tb_cb_filter_seq.sv
// Scoreboard bench for cb_filter_seq: the driver pushes model-predicted
// responses, a negedge monitor pops and compares them.
module tb_cb_filter_seq;
    import cb_filter_pkg::*;

    localparam int K = 3;
    localparam logic [31:0] KEY = 32'h0000_1234;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [31:0] req_key_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_hit_o;
    logic        rsp_err_o;
    logic        filter_empty_o;

    always #5 clk = ~clk;

    cb_filter_seq dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_key_i      (req_key_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_hit_o      (rsp_hit_o),
        .rsp_err_o      (rsp_err_o),
        .filter_empty_o (filter_empty_o)
    );

    typedef struct { logic hit; logic err; int lat; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    bit rsp_seen = 0;
    bit rand_bp  = 0;
    int model_cnt [16];

    function void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference hash: XOR, 32-bit rotate-left, fold nibbles.
    function automatic int m_idx(input logic [31:0] key, input int h);
        logic [31:0] x, r;
        int s, acc;
        x = key ^ EgSeeds[h].XorSeed;
        s = int'(EgSeeds[h].PermuteSeed % 32);
        r = (s == 0) ? x : ((x << s) | (x >> (32 - s)));
        acc = 0;
        for (int j = 0; j < 8; j++) acc = acc ^ int'((r >> (4 * j)) & 32'hF);
        return acc;
    endfunction

    function automatic exp_t model_apply(input logic [1:0] op, input logic [31:0] key);
        exp_t e;
        int ix [K];
        bit all_nz, over;
        all_nz = 1; over = 0;
        for (int h = 0; h < K; h++) begin
            ix[h] = m_idx(key, h);
            if (model_cnt[ix[h]] == 0) all_nz = 0;
            if (model_cnt[ix[h]] > 15 - K) over = 1;
        end
        e.hit = all_nz; e.err = 1'b0; e.lat = K + 1;
        if (op == 2'd1) begin
            e.err = over;
            if (!over) begin
                e.lat = 2 * K + 1;
                for (int h = 0; h < K; h++) if (model_cnt[ix[h]] < 15) model_cnt[ix[h]]++;
            end
        end else if (op == 2'd2) begin
            e.err = !all_nz;
            if (all_nz) begin
                e.lat = 2 * K + 1;
                for (int h = 0; h < K; h++) if (model_cnt[ix[h]] > 0) model_cnt[ix[h]]--;
            end
        end
        return e;
    endfunction

    function automatic int model_empty();
        for (int k = 0; k < 16; k++) if (model_cnt[k] != 0) return 0;
        return 1;
    endfunction

    // Cycle counter and request-acceptance timestamp.
    always @(posedge clk) begin
        if (!rst_i && req_valid_i && req_ready_o) acc_cyc = cyc;
        cyc = cyc + 1;
    end

    // Monitor: compares every presented response cycle against the queue head.
    always @(negedge clk) begin
        if (rst_i) begin
            rsp_seen = 0;
        end else if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                if (!rsp_seen) begin
                    rsp_seen = 1;
                    chk("rsp_latency", cyc - acc_cyc, exp_q[0].lat);
                end
                chk("rsp_hit", int'(rsp_hit_o), int'(exp_q[0].hit));
                chk("rsp_err", int'(rsp_err_o), int'(exp_q[0].err));
                chk("req_ready_in_resp", int'(req_ready_o), 0);
                if (rsp_ready_i) begin
                    exp_q.delete(0);
                    rsp_seen = 0;
                end
            end
        end
    end

    // Random response backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] key);
        int w;
        w = 0;
        req_valid_i = 1'b1; req_op_i = op; req_key_i = key;
        while (!req_ready_o && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready_o) begin
            chk("req_ready_timeout", 0, 1);
            req_valid_i = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_valid_i = 1'b0;
            exp_q.push_back(model_apply(op, key));
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || !req_ready_o) && w < 300) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 300) begin
            chk("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        chk("filter_empty", int'(filter_empty_o), model_empty());
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        logic [31:0] key;
        rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 2'd0; req_key_i = 32'd0;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) model_cnt[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", int'(req_ready_o), 1);
        chk("reset_rsp_valid", int'(rsp_valid_o), 0);
        chk("reset_empty", int'(filter_empty_o), 1);
        chk("reset_hit", int'(rsp_hit_o), 0);
        chk("reset_err", int'(rsp_err_o), 0);
        @(posedge clk); #1;

        // Directed: lookup on empty, insert, lookup, remove twice.
        send(2'd0, KEY); wait_idle();
        send(2'd1, KEY); wait_idle();
        send(2'd0, KEY); wait_idle();
        send(2'd2, KEY); wait_idle();
        send(2'd2, KEY); wait_idle();
        send(2'd3, KEY); wait_idle();

        // Saturation: 13 accepted inserts, the 14th refused.
        for (int n = 0; n < 14; n++) begin
            send(2'd1, KEY); wait_idle();
        end
        send(2'd0, KEY); wait_idle();

        // Response backpressure for 5 cycles.
        rsp_ready_i = 1'b0;
        send(2'd0, KEY);
        w = 0;
        while (!rsp_valid_o && w < 50) begin
            @(posedge clk); #1; w++;
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_valid_held", int'(rsp_valid_o), 1);
        end
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        wait_idle();

        // Reset in the middle of an update: no response, counters cleared.
        send(2'd2, KEY);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_in_update", int'(req_ready_o), 0);
        rst_i = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 16; k++) model_cnt[k] = 0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_upd_ready", int'(req_ready_o), 1);
        chk("rst_upd_valid", int'(rsp_valid_o), 0);
        chk("rst_upd_empty", int'(filter_empty_o), 1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        send(2'd0, KEY); wait_idle();

        // Randomized traffic over a small key pool with random backpressure.
        rand_bp = 1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       key = KEY;
                1:       key = 32'hDEAD_BEEF;
                2:       key = 32'h0000_0001;
                default: key = $urandom;
            endcase
            send(2'($urandom_range(0, 3)), key);
            wait_idle();
        end
        rand_bp = 0;
        rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
